data_memory_stage: RTL and testbench

Multi-cycle data-memory stage sitting directly downstream of the ALU in the MIPS datapath. Takes the ALU result as a byte address for LW/SW, performs a word read or write on an internal RAM after a parameterizable number of wait states, and signals completion with a one-cycle pulse. Control provides a start strobe and holds the pipeline while the stage is busy. Misaligned, out-of-range or ill-formed requests are reported as errors and never touch memory.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/data_ram.sv | 32 +++
 rtl/data_memory_stage.sv | 145 ++++++++++++++
 tb/tb_data_memory_stage.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions.
//   state_t               : data-memory stage FSM states (IDLE, WAIT, DONE)
//   DEFAULT_BASE_ADDR     : byte address of word 0 of the data segment
//   word_index_width()    : bits needed to index a word array of a given depth
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;

  // A depth of 1 still needs a one-bit index so the port never collapses.
  function automatic int word_index_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/data_ram.sv
// Single-port word-addressed RAM, synchronous write and synchronous read.
// Contents are never reset.
//   clk   : clock
//   we    : write enable, mem[addr] <= wdata on the rising edge
//   re    : read enable, rdata <= mem[addr] on the rising edge
//   addr  : word index
//   wdata : write data
//   rdata : registered read data, holds between reads
module data_ram #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_memory_stage.sv
// Multi-cycle data-memory stage for LW/SW. A Start strobe captures the
// request; valid accesses wait LATENCY cycles, then touch the RAM and pulse
// Done. Misaligned, out-of-range or read+write requests complete at once
// with AddrError set and never touch memory.
//   clk       : clock, rising edge
//   reset     : synchronous, active-low
//   Start     : request strobe, accepted in IDLE or DONE
//   MemRead   : load request
//   MemWrite  : store request
//   Address   : byte address (ALU result)
//   WriteData : store data
//   ReadData  : load result, held until the next successful load
//   Busy      : request in wait/access phase
//   Done      : one-cycle completion pulse
//   AddrError : qualifies Done, request rejected
module data_memory_stage
  import mips_pkg::*;
#(
  parameter int          MEMORY_DEPTH = 256,
  parameter logic [31:0] BASE_ADDR    = DEFAULT_BASE_ADDR,
  parameter int          LATENCY      = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Busy,
  output logic        Done,
  output logic        AddrError
);

  localparam int          IDX_W     = word_index_width(MEMORY_DEPTH);
  localparam logic [32:0] BYTE_SPAN = 33'(MEMORY_DEPTH) << 2;
  localparam logic [2:0]  LAT       = 3'(LATENCY);

  state_t state_reg, state_next;
  logic [2:0]       cnt_reg, cnt_next;
  logic             err_reg, err_next;
  logic             rd_reg, wr_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [31:0]      wdata_reg;
  logic             rd_valid_reg;

  logic        capture;
  logic        access;
  logic [31:0] offset;
  logic        req_error;
  logic        ram_we, ram_re;
  logic [31:0] ram_q;

  // The check is evaluated on the values being captured this edge, so an
  // error request can already be in DONE on the cycle after Start.
  assign offset    = Address - BASE_ADDR;  // wraps for addresses below base
  assign req_error = (Address[1:0] != 2'b00)
                   || ({1'b0, offset} >= BYTE_SPAN)
                   || (MemRead && MemWrite);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    err_next   = 1'b0;
    capture    = 1'b0;
    access     = 1'b0;
    unique case (state_reg)
      IDLE, DONE: begin
        state_next = IDLE;
        if (Start) begin
          capture = 1'b1;
          if (req_error) begin
            state_next = DONE;
            err_next   = 1'b1;
          end else if (MemRead || MemWrite) begin
            state_next = WAIT;
            cnt_next   = LAT;
          end else begin
            state_next = DONE;
          end
        end
      end
      WAIT: begin
        if (cnt_reg != 3'd0) begin
          cnt_next = cnt_reg - 3'd1;
        end else begin
          access     = 1'b1;
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= 3'd0;
      err_reg      <= 1'b0;
      rd_reg       <= 1'b0;
      wr_reg       <= 1'b0;
      idx_reg      <= '0;
      wdata_reg    <= 32'd0;
      rd_valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
      if (capture) begin
        rd_reg    <= MemRead;
        wr_reg    <= MemWrite;
        idx_reg   <= offset[IDX_W+1:2];
        wdata_reg <= WriteData;
      end
      if (access && rd_reg) begin
        rd_valid_reg <= 1'b1;
      end
    end
  end

  // Reset gates the enables so an access on the same edge as reset is dropped.
  assign ram_we = reset && access && wr_reg;
  assign ram_re = reset && access && rd_reg;

  data_ram #(
    .DEPTH  (MEMORY_DEPTH),
    .ADDR_W (IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (idx_reg),
    .wdata (wdata_reg),
    .rdata (ram_q)
  );

  // The RAM output register has no reset; masking it until the first load
  // after reset gives ReadData its reset value of zero.
  assign ReadData  = rd_valid_reg ? ram_q : 32'd0;
  assign Busy      = (state_reg == WAIT);
  assign Done      = (state_reg == DONE);
  assign AddrError = err_reg;

endmodule

// File: tb/tb_data_memory_stage.sv
module tb_data_memory_stage;
  import mips_pkg::*;

  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h1001_0000;
  localparam int          LAT0  = 2;
  localparam int          LAT1  = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        reset_s [2];
  logic        start_s [2];
  logic        mr_s    [2];
  logic        mw_s    [2];
  logic [31:0] addr_s  [2];
  logic [31:0] wd_s    [2];
  logic [31:0] rd_s    [2];
  logic        busy_s  [2];
  logic        done_s  [2];
  logic        err_s   [2];

  data_memory_stage #(.MEMORY_DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT0)) u_dut0 (
    .clk(clk), .reset(reset_s[0]), .Start(start_s[0]), .MemRead(mr_s[0]),
    .MemWrite(mw_s[0]), .Address(addr_s[0]), .WriteData(wd_s[0]),
    .ReadData(rd_s[0]), .Busy(busy_s[0]), .Done(done_s[0]), .AddrError(err_s[0])
  );

  data_memory_stage #(.MEMORY_DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT1)) u_dut1 (
    .clk(clk), .reset(reset_s[1]), .Start(start_s[1]), .MemRead(mr_s[1]),
    .MemWrite(mw_s[1]), .Address(addr_s[1]), .WriteData(wd_s[1]),
    .ReadData(rd_s[1]), .Busy(busy_s[1]), .Done(done_s[1]), .AddrError(err_s[1])
  );

  // Reference model: word array per DUT plus the last value a load returned.
  logic [31:0] mdl    [2][DEPTH];
  logic [31:0] rd_exp [2];
  int          done_cyc;

  int pass_cnt = 0;
  int total    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? LAT0 : LAT1;
  endfunction

  // Error rule from plain signed arithmetic on the byte distance from base.
  function automatic bit is_err(input logic [31:0] a, input bit r, input bit w);
    longint off;
    off = longint'(a) - longint'(BASE);
    return (a % 4 != 0) || (off < 0) || (off >= 4 * DEPTH) || (r && w);
  endfunction

  // Issue one request at a negedge; returns at the negedge of the Done cycle
  // so the next call is a back-to-back request.
  task automatic req(input int d, input bit r, input bit w, input logic [31:0] a,
                     input logic [31:0] wd, input string tag);
    bit e, acc;
    int exp_k, done_k, widx;
    e     = is_err(a, r, w);
    acc   = !e && (r || w);
    exp_k = acc ? lat_of(d) + 1 : 0;
    done_k = -1;
    start_s[d] = 1'b1; mr_s[d] = r; mw_s[d] = w; addr_s[d] = a; wd_s[d] = wd;
    @(posedge clk);
    for (int k = 0; k <= exp_k + 3; k++) begin
      @(negedge clk);
      if (k == 0) begin
        // Inputs after capture must not matter.
        start_s[d] = 1'b0;
        mr_s[d] = 1'($urandom); mw_s[d] = 1'($urandom);
        addr_s[d] = $urandom; wd_s[d] = $urandom;
      end
      if (done_s[d]) begin
        done_k = k;
        break;
      end
      chk({tag, " busy"}, 32'(busy_s[d]), 32'(acc));
      chk({tag, " err_idle"}, 32'(err_s[d]), 32'd0);
    end
    chk({tag, " done"}, 32'(done_s[d]), 32'd1);
    chk({tag, " latency"}, done_k, exp_k);
    chk({tag, " addr_err"}, 32'(err_s[d]), 32'(e));
    chk({tag, " busy_in_done"}, 32'(busy_s[d]), 32'd0);
    if (acc) begin
      widx = int'((a - BASE) >> 2);
      if (w) mdl[d][widx] = wd;
      if (r) rd_exp[d] = mdl[d][widx];
    end
    chk({tag, " rdata"}, rd_s[d], rd_exp[d]);
    done_cyc = cyc;
    $display("dut%0d %s r=%0b w=%0b addr=%h wd=%h done_k=%0d err=%0b rdata=%h",
             d, tag, r, w, a, wd, done_k, err_s[d], rd_s[d]);
  endtask

  task automatic check_quiet(input int d, input string tag);
    chk({tag, " busy"}, 32'(busy_s[d]), 32'd0);
    chk({tag, " done"}, 32'(done_s[d]), 32'd0);
    chk({tag, " addr_err"}, 32'(err_s[d]), 32'd0);
    chk({tag, " rdata"}, rd_s[d], 32'd0);
  endtask

  initial begin
    int c1, kind, wi, sel;
    bit r, w;
    logic [31:0] a;
    for (int d = 0; d < 2; d++) begin
      reset_s[d] = 1'b0; start_s[d] = 1'b0; mr_s[d] = 1'b0; mw_s[d] = 1'b0;
      addr_s[d] = 32'd0; wd_s[d] = 32'd0; rd_exp[d] = 32'd0;
    end
    repeat (3) @(negedge clk);
    reset_s[0] = 1'b1; reset_s[1] = 1'b1;
    check_quiet(0, "reset0");
    check_quiet(1, "reset1");
    $display("reset released, outputs idle");

    // Directed sequence on the LATENCY=2 instance.
    req(0, 0, 1, 32'h1001_0004, 32'hDEAD_BEEF, "sw_deadbeef");
    req(0, 1, 0, 32'h1001_0004, 32'h0, "lw_deadbeef");
    chk("lw_deadbeef value", rd_s[0], 32'hDEAD_BEEF);
    req(0, 1, 0, 32'h1001_0002, 32'h0, "lw_misaligned");
    req(0, 0, 1, 32'h1001_0006, 32'hBAD0_BAD0, "sw_misaligned");
    req(0, 1, 0, 32'h1001_0400, 32'h0, "lw_out_of_range");
    req(0, 1, 0, 32'h1000_FFFC, 32'h0, "lw_below_base");
    req(0, 1, 1, 32'h1001_0004, 32'h0, "rd_and_wr");
    req(0, 0, 0, 32'h1001_0004, 32'h0, "noop");
    req(0, 1, 0, 32'h1001_0004, 32'h0, "lw_after_errors");
    chk("memory intact", rd_s[0], 32'hDEAD_BEEF);
    @(negedge clk);

    // Prefill words 0..15 of both instances with known data.
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++)
        req(d, 0, 1, BASE + 32'(4 * i), $urandom, "prefill");

    // Reset asserted at the negedge before the committing edge of a store.
    req(0, 0, 1, 32'h1001_0008, 32'h0000_1111, "sw_1111");
    start_s[0] = 1'b1; mr_s[0] = 1'b0; mw_s[0] = 1'b1;
    addr_s[0] = 32'h1001_0008; wd_s[0] = 32'h0000_5555;
    @(posedge clk);
    for (int k = 0; k <= LAT0; k++) begin
      @(negedge clk);
      start_s[0] = 1'b0;
      chk("abort busy", 32'(busy_s[0]), 32'd1);
    end
    reset_s[0] = 1'b0;
    @(negedge clk);
    check_quiet(0, "abort_reset");
    reset_s[0] = 1'b1;
    rd_exp[0] = 32'd0;
    $display("dut0 store 0x5555 aborted by reset");
    req(0, 1, 0, 32'h1001_0008, 32'h0, "lw_after_abort");
    chk("abort kept old", rd_s[0], 32'h0000_1111);
    @(negedge clk);

    // LATENCY=0 back-to-back store then load.
    req(1, 0, 1, 32'h1001_0000, 32'h0000_1234, "b2b_sw");
    c1 = done_cyc;
    req(1, 1, 0, 32'h1001_0000, 32'h0, "b2b_lw");
    chk("b2b value", rd_s[1], 32'h0000_1234);
    chk("b2b done spacing", done_cyc - c1, 32'd2);
    @(negedge clk);

    // Randomized traffic on both instances.
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 40; n++) begin
        kind = $urandom_range(0, 9);
        wi   = $urandom_range(0, 15);
        sel  = $urandom_range(0, 9);
        r = (sel < 5) || (sel == 9);
        w = (sel >= 5);
        a = BASE + 32'(4 * wi);
        case (kind)
          6: a = BASE + 32'(4 * wi) + 32'($urandom_range(1, 3));
          7: a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 255));
          8: a = BASE - 32'(4 * $urandom_range(1, 64));
          9: begin r = 1'b0; w = 1'b0; end
          default: ;
        endcase
        req(d, r, w, a, $urandom, "rand");
        if ($urandom_range(0, 3) == 0) @(negedge clk);
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
